// File: rtl/sprite_compositor_pkg.sv
// Shared types, register map constants and colour helpers for the sprite compositor.
package sprite_compositor_pkg;

    // Per-sprite field offsets (address[2:0])
    localparam logic [2:0] FLD_X    = 3'd0;
    localparam logic [2:0] FLD_Y    = 3'd1;
    localparam logic [2:0] FLD_CTRL = 3'd2;

    // Global block field offsets
    localparam logic [2:0] FLD_BG   = 3'd0;
    localparam logic [2:0] FLD_KEY  = 3'd1;

    // Sprite selector value that addresses the global block
    localparam logic [5:0] GLOBAL_IDX = 6'd63;

    // Magenta is the conventional "don't draw" colour
    localparam logic [15:0] KEY_RESET = 16'hF81F;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } sprite_regs_t;

    // Zero-fill the low bits rather than replicate, so 0x1F maps to 248
    function automatic logic [23:0] rgb565_to_rgb888(input rgb565_t d);
        return {d.r, 3'b000, d.g, 2'b00, d.b, 3'b000};
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Avalon-MM write-only register bus into the sprite compositor.
interface sprite_compositor_if;
    logic        chipselect;
    logic        write;
    logic [8:0]  address;
    logic [31:0] writedata;

    modport master (output chipselect, output write, output address, output writedata);
    modport slave  (input  chipselect, input  write, input  address, input  writedata);
endinterface

// File: rtl/sprite_compositor_sprite_hit.sv
// Per-channel hit test and sprite ROM address generation (combinational).
module sprite_hit
    import sprite_compositor_pkg::*;
#(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int AW    = $clog2(SPR_W * SPR_H)
) (
    input  logic [9:0]    px,
    input  logic [9:0]    py,
    input  sprite_regs_t  regs,
    output logic          hit,
    output logic [AW-1:0] addr
);
    localparam int WB = $clog2(SPR_W);
    localparam int HB = $clog2(SPR_H);

    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic        in_x_s;
    logic        in_y_s;

    // 11-bit offsets; the >= guards keep pixels left of / above the sprite out of range
    always_comb begin
        dx_s   = {1'b0, px} - {1'b0, regs.x};
        dy_s   = {1'b0, py} - {1'b0, regs.y};
        in_x_s = (px >= regs.x) && (dx_s < 11'(SPR_W));
        in_y_s = (py >= regs.y) && (dy_s < 11'(SPR_H));
        hit    = regs.en && in_x_s && in_y_s;
        if (hit) begin
            // Power-of-2 width: row*SPR_W + col is just a concatenation
            addr = AW'({dy_s[HB-1:0], dx_s[WB-1:0]});
        end else begin
            addr = '0;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: double-buffered registers, hit test, ROM fetch, priority mux.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int VACTIVE     = 480,
    parameter int AW          = $clog2(SPR_W * SPR_H)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [10:0]               hcount,
    input  logic [9:0]                vcount,
    input  logic                      blank_n_in,
    sprite_compositor_if.slave        bus,
    output logic [NUM_SPRITES*AW-1:0] spr_addr,
    input  logic [NUM_SPRITES*16-1:0] spr_data,
    output logic [7:0]                VGA_R,
    output logic [7:0]                VGA_G,
    output logic [7:0]                VGA_B,
    output logic                      blank_n_out,
    output logic                      frame_commit
);
    sprite_regs_t shadow_q [NUM_SPRITES];
    sprite_regs_t shadow_d [NUM_SPRITES];
    sprite_regs_t active_q [NUM_SPRITES];
    sprite_regs_t active_d [NUM_SPRITES];
    logic [15:0] bg_sh_q, bg_sh_d, key_sh_q, key_sh_d;
    logic [15:0] bg_act_q, bg_act_d, key_act_q, key_act_d;

    logic [NUM_SPRITES-1:0]    hit_s, hit1_q, hit1_d, hit2_q, hit2_d;
    logic [NUM_SPRITES*AW-1:0] addr_s, spr_addr_q, spr_addr_d;
    logic blank1_q, blank1_d, blank2_q, blank2_d, blank3_q, blank3_d;
    logic frame_commit_q, frame_commit_d;
    logic [23:0] rgb_q, rgb_d;
    rgb565_t pix_s;

    logic       wr_s;
    logic       commit_s;
    logic [5:0] sel_s;
    logic [2:0] fld_s;
    logic       unused_wdata_s;

    assign wr_s           = bus.chipselect && bus.write;
    assign sel_s          = bus.address[8:3];
    assign fld_s          = bus.address[2:0];
    assign unused_wdata_s = ^bus.writedata[31:16];
    assign commit_s       = (hcount == 11'd0) && (vcount == 10'(VACTIVE));

    // Bus writes land in the shadow bank only
    always_comb begin
        shadow_d = shadow_q;
        bg_sh_d  = bg_sh_q;
        key_sh_d = key_sh_q;
        if (wr_s && (sel_s == GLOBAL_IDX)) begin
            case (fld_s)
                FLD_BG:  bg_sh_d  = bus.writedata[15:0];
                FLD_KEY: key_sh_d = bus.writedata[15:0];
                default: bg_sh_d  = bg_sh_q;
            endcase
        end else if (wr_s) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (sel_s == 6'(i)) begin
                    case (fld_s)
                        FLD_X:    shadow_d[i].x  = bus.writedata[9:0];
                        FLD_Y:    shadow_d[i].y  = bus.writedata[9:0];
                        FLD_CTRL: shadow_d[i].en = bus.writedata[0];
                        default:  shadow_d[i]    = shadow_q[i];
                    endcase
                end else begin
                    shadow_d[i] = shadow_q[i];
                end
            end
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Active bank copies the pre-write shadow once per frame, at the start of vblank
    always_comb begin
        if (commit_s) begin
            active_d  = shadow_q;
            bg_act_d  = bg_sh_q;
            key_act_d = key_sh_q;
        end else begin
            active_d  = active_q;
            bg_act_d  = bg_act_q;
            key_act_d = key_act_q;
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .AW    (AW)
        ) u_hit (
            .px   (hcount[10:1]),
            .py   (vcount),
            .regs (active_q[g]),
            .hit  (hit_s[g]),
            .addr (addr_s[g*AW +: AW])
        );
    end

    // Pipeline advance: hit/blank travel alongside the ROM read so they meet its data
    always_comb begin
        hit1_d         = hit_s;
        spr_addr_d     = addr_s;
        blank1_d       = blank_n_in;
        hit2_d         = hit1_q;
        blank2_d       = blank1_q;
        blank3_d       = blank2_q;
        frame_commit_d = commit_s;
    end

    // Lowest-index opaque sprite wins; walk downward so the last assignment is the winner
    always_comb begin
        pix_s = rgb565_t'(bg_act_q);
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit2_q[i] && (spr_data[i*16 +: 16] != key_act_q)) begin
                pix_s = rgb565_t'(spr_data[i*16 +: 16]);
            end else begin
                pix_s = pix_s;
            end
        end
        if (blank2_q) begin
            rgb_d = rgb565_to_rgb888(pix_s);
        end else begin
            rgb_d = 24'd0;
        end
    end

    // Shadow and active register banks
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            bg_sh_q   <= 16'h0000;
            key_sh_q  <= KEY_RESET;
            bg_act_q  <= 16'h0000;
            key_act_q <= KEY_RESET;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            bg_sh_q   <= bg_sh_d;
            key_sh_q  <= key_sh_d;
            bg_act_q  <= bg_act_d;
            key_act_q <= key_act_d;
        end
    end

    // Pixel pipeline and registered outputs; reset drops any in-flight pixels
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit1_q         <= '0;
            hit2_q         <= '0;
            spr_addr_q     <= '0;
            blank1_q       <= 1'b0;
            blank2_q       <= 1'b0;
            blank3_q       <= 1'b0;
            frame_commit_q <= 1'b0;
            rgb_q          <= 24'd0;
        end else begin
            hit1_q         <= hit1_d;
            hit2_q         <= hit2_d;
            spr_addr_q     <= spr_addr_d;
            blank1_q       <= blank1_d;
            blank2_q       <= blank2_d;
            blank3_q       <= blank3_d;
            frame_commit_q <= frame_commit_d;
            rgb_q          <= rgb_d;
        end
    end

    assign spr_addr     = spr_addr_q;
    assign VGA_R        = rgb_q[23:16];
    assign VGA_G        = rgb_q[15:8];
    assign VGA_B        = rgb_q[7:0];
    assign blank_n_out  = blank3_q;
    assign frame_commit = frame_commit_q;

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-channel sprite compositor between the `vga_counters` timing generator and the VGA DAC pins. It takes `hcount`/`vcount`/blanking from the counters, drives one address per external sprite ROM, and resolves the returned RGB565 pixels into 24-bit RGB. Over the single-use sprite logic it adds:

- per-sprite enable;
- fixed index priority;
- colour-key transparency;
- a background colour register;
- full-width coordinates;
- double-buffered registers, committed once per frame at vertical blank for tear-free updates.

## Interface
Parameters:
- `NUM_SPRITES`, 8, number of sprite channels (1–63)
- `SPR_W`, 32, sprite width in pixels (power of 2)
- `SPR_H`, 32, sprite height in pixels (power of 2)
- `VACTIVE`, 480, active lines; commit line
- `AW`, `$clog2(SPR_W*SPR_H)`, sprite ROM address width (derived)

Ports:
- `clk`  in  1  system clock, 50 MHz
- `reset_n`  in  1  synchronous, active-low reset
- `hcount`  in  11  horizontal count from `vga_counters`; pixel column = `hcount[10:1]`
- `vcount`  in  10  line count from `vga_counters`
- `blank_n_in`  in  1  `VGA_BLANK_n` from `vga_counters`
- `chipselect`, `write`  in  1 each  Avalon-MM slave write strobe
- `address`  in  9  register address
- `writedata`  in  32  register data
- `spr_addr`  out  `NUM_SPRITES*AW`  per-sprite ROM address; sprite i at `[i*AW +: AW]`
- `spr_data`  in  `NUM_SPRITES*16`  per-sprite RGB565 ROM data; 1-cycle synchronous read
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  composited colour
- `blank_n_out`  out  1  `blank_n_in` delayed to align with RGB
- `frame_commit`  out  1  one-cycle pulse when shadow registers are copied to active

## Operation
Register map:
- `address[8:3]` selects sprite `s`, `address[2:0]` selects the field.
  - Field 0: `x[9:0]`
  - Field 1: `y[9:0]`
  - Field 2: `ctrl[0]` = enable
  - Fields 3–7: ignored
- `s = 63` is the global block:
  - Field 0: `bg[15:0]` (RGB565)
  - Field 1: `key[15:0]` (transparent colour)
- Writes with `NUM_SPRITES <= s < 63` are ignored. There is no read path.

Shadow/active register banks:
- Writes update the shadow bank only.
- The active bank is loaded from shadow when `hcount==0 && vcount==VACTIVE`. `frame_commit` pulses on that cycle.
- If a write lands on the commit cycle, active takes the pre-write shadow value; the new value commits next frame.

Hit test, per sprite, with `px = hcount[10:1]` and `py = vcount`:
- `hit = en && px>=x && (px-x)<SPR_W && py>=y && (py-y)<SPR_H`.
- Subtraction is performed at 11 bits, so there is no wrap. Sprites crossing column 639 or row 479 clip.
- `spr_addr = (py-y)*SPR_W + (px-x)`, truncated to `AW` bits. When there is no hit, the address holds 0.

Compositing:
- Candidates are sprites whose hit bit is set and whose `spr_data != key`.
- The lowest index among candidates wins. With no candidate the output is `bg`.
- RGB565 expands as `R={d[15:11],3'b0}`, `G={d[10:5],2'b0}`, `B={d[4:0],3'b0}`.
- When the delayed blank is 0, RGB is forced to 0.

Reset (`reset_n` low at a `clk` edge):
- Shadow and active registers: all `x`, `y`, `en` = 0; `bg` = 0x0000; `key` = 0xF81F.
- Pipeline registers, `spr_addr`, RGB outputs, `blank_n_out` and `frame_commit` all go to 0.
- A reset mid-frame discards in-flight pixels. Output is valid 3 cycles after release.

## Timing
- Stage 0 → 1: hit bits and `spr_addr` registered. `hit` and `blank` are carried forward.
- Stage 1 → 2: ROM returns `spr_data`.
- Stage 2 → 3: priority mux and blank gating registered to `VGA_*`.
- Total latency from `hcount` to `VGA_*`/`blank_n_out` is 3 `clk`. Every pixel column occupies 2 `clk`, so the pipeline is fully streaming.
- Register writes take one `clk` into shadow. `chipselect&&write` is accepted every cycle with no wait states.

## Structure
- `sprite_compositor_pkg`:
  - Register field offsets.
  - `GLOBAL_IDX=63`.
  - Reset key `16'hF81F`.
  - `rgb565_t` packed struct.
  - `sprite_regs_t` struct (`x`, `y`, `en`).
  - `rgb565_to_rgb888` function.
- One sub-module, `sprite_hit`: per-channel hit test and address generation, generated `NUM_SPRITES` times.
- Priority mux and register banks live in the top module.

## Test plan
1. **Reset, nothing enabled:** hold `reset_n` low 4 cycles, release, `bg`=0x001F, no sprites enabled → after the commit, active pixels read RGB (0,0,248); blanked pixels read 0.
2. **Single sprite placement:** sprite 0 at x=100, y=50, enabled, ROM = 0xF800 → `VGA_R`=248 exactly for px 100–131 and lines 50–81, appearing 3 clk after the matching `hcount`. `spr_addr` at (px=105, py=52) = 69.
3. **Overlap and transparency:** sprites 0 and 1 overlap at the same x/y. Sprite 0 data = `key`, sprite 1 data = 0x07E0 → output G=252. With sprite 0 data = 0xFFFF → output (248,252,248).
4. **Tear-free update:** write x=200 at line 100 mid-frame → remainder of the frame still draws at the old x. `frame_commit` pulses at `vcount`=480, `hcount`=0, and the next frame draws at 200. A write on the commit cycle is deferred one frame.
5. **Right-edge clip:** x=630 → sprite drawn at px 630–639 only. No pixel appears at px 0–21 of the next line.
6. **Ignored writes:** write to `s`=`NUM_SPRITES`, and to field 5 of sprite 0 → no change in any active register or output.
